myo_spi_scanner: RTL and testbench

- Parametrised successor to the single-motor SPI control loop: one controller scans up to NUM_MOTORS motor boards over a shared SPI master, one frame per motor in round-robin order.
- Each frame sends the motor's PWM reference and collects position, velocity and spring displacement into per-motor result registers.
- Sits between the PID controllers/HPS and the existing spi_master, and drives one active-low slave-select per motor.
- Adds what the single-motor loop lacks: enable mask, single-shot/continuous modes, inter-frame gap, and a per-motor timeout with error flags.

---
 rtl/myo_spi_pkg.sv | 15 +
 rtl/myo_next_enabled.sv | 25 ++
 rtl/myo_spi_scanner.sv | 188 ++++++++++++++++++
 tb/tb_myo_spi_scanner.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_spi_pkg.sv
// rtl/myo_spi_pkg.sv - shared state type and frame layout for the motor SPI scanner
package myo_spi_pkg;

  typedef enum logic [1:0] {IDLE, SELECT, XFER, GAP} state_t;

  localparam int FRAME_WORDS = 5;

  // Receive word order inside one frame
  localparam logic [2:0] IDX_STATUS = 3'd0;
  localparam logic [2:0] IDX_POS_HI = 3'd1;
  localparam logic [2:0] IDX_POS_LO = 3'd2;
  localparam logic [2:0] IDX_VEL    = 3'd3;
  localparam logic [2:0] IDX_DISP   = 3'd4;

endpackage

// File: rtl/myo_next_enabled.sv
// rtl/myo_next_enabled.sv - lowest set mask bit above cur (or from bit 0 when from_zero)
module myo_next_enabled #(
  parameter int N  = 10,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] cur,
  input  logic          from_zero,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Descending scan so the lowest qualifying index is the last one written
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (from_zero || i > int'(cur))) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/myo_spi_scanner.sv
// rtl/myo_spi_scanner.sv - round-robin SPI frame scanner over NUM_MOTORS motor boards
module myo_spi_scanner
  import myo_spi_pkg::*;
#(
  parameter int NUM_MOTORS     = 10,
  parameter int WORD_W         = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [NUM_MOTORS-1:0]        motor_en,
  input  logic [NUM_MOTORS*WORD_W-1:0] pwm_ref,
  input  logic                         di_req,
  input  logic                         wr_ack,
  input  logic                         do_valid,
  input  logic [WORD_W-1:0]            do_i,
  output logic [WORD_W-1:0]            di_o,
  output logic                         wren,
  output logic [NUM_MOTORS-1:0]        ss_n_o,
  output logic [NUM_MOTORS*32-1:0]     position,
  output logic [NUM_MOTORS*WORD_W-1:0] velocity,
  output logic [NUM_MOTORS*WORD_W-1:0] displacement,
  output logic [NUM_MOTORS-1:0]        err_timeout,
  output logic                         frame_done,
  output logic [IW-1:0]                frame_motor,
  output logic                         scan_done,
  output logic                         busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t                  state, state_nx;
  logic [IW-1:0]           m;
  logic [NUM_MOTORS-1:0]   en_q;
  logic                    cont_q;
  logic [2:0]              tx_idx, rx_idx;
  logic                    wr_pend;
  logic [TW-1:0]           to_cnt;
  logic [GW-1:0]           gap_cnt;
  logic [WORD_W-1:0]       pos_hi, pos_lo, vel_s;
  logic [IW-1:0]           first_idx, next_idx;
  logic                    first_found, next_found;
  logic                    rx_done, timed_out, gap_end;

  myo_next_enabled #(.N(NUM_MOTORS), .IW(IW)) u_first (
    .mask(motor_en), .cur('0), .from_zero(1'b1), .idx(first_idx), .found(first_found)
  );

  myo_next_enabled #(.N(NUM_MOTORS), .IW(IW)) u_next (
    .mask(en_q), .cur(m), .from_zero(1'b0), .idx(next_idx), .found(next_found)
  );

  assign rx_done   = (rx_idx == 3'(FRAME_WORDS));
  assign timed_out = (state == XFER) && !rx_done && !do_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign gap_end   = (state == GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));

  always_comb begin
    state_nx = state;
    ss_n_o   = '1;
    wren     = 1'b0;
    di_o     = '0;
    case (state)
      IDLE: if ((start || continuous) && first_found) state_nx = SELECT;
      SELECT: begin
        ss_n_o[m] = 1'b0;
        state_nx  = XFER;
      end
      XFER: begin
        ss_n_o[m] = 1'b0;
        // wren stays up after di_req drops until the master acknowledges
        wren = (tx_idx < 3'(FRAME_WORDS)) && (di_req || wr_pend);
        if (wren && tx_idx == 3'd0) di_o = pwm_ref[int'(m)*WORD_W +: WORD_W];
        if (rx_done || timed_out) state_nx = GAP;
      end
      GAP: begin
        if (gap_end) begin
          if (next_found)                                  state_nx = SELECT;
          else if (cont_q && continuous && first_found)    state_nx = SELECT;
          else                                             state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      m            <= '0;
      en_q         <= '0;
      cont_q       <= 1'b0;
      tx_idx       <= '0;
      rx_idx       <= '0;
      wr_pend      <= 1'b0;
      to_cnt       <= '0;
      gap_cnt      <= '0;
      pos_hi       <= '0;
      pos_lo       <= '0;
      vel_s        <= '0;
      position     <= '0;
      velocity     <= '0;
      displacement <= '0;
      err_timeout  <= '0;
      frame_done   <= 1'b0;
      frame_motor  <= '0;
      scan_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      scan_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nx == SELECT) begin
            en_q   <= motor_en;
            cont_q <= continuous;
            m      <= first_idx;
            busy   <= 1'b1;
          end
        end
        SELECT: begin
          tx_idx  <= '0;
          rx_idx  <= '0;
          to_cnt  <= '0;
          wr_pend <= 1'b0;
        end
        XFER: begin
          if (wren) begin
            if (wr_ack) begin
              tx_idx  <= tx_idx + 3'd1;
              wr_pend <= 1'b0;
            end else begin
              wr_pend <= 1'b1;
            end
          end
          to_cnt <= do_valid ? '0 : to_cnt + 1'b1;
          if (do_valid && !rx_done) begin
            rx_idx <= rx_idx + 3'd1;
            case (rx_idx)
              IDX_POS_HI: pos_hi <= do_i;
              IDX_POS_LO: pos_lo <= do_i;
              IDX_VEL:    vel_s  <= do_i;
              IDX_DISP: begin
                // All three results land together so readers never see a mixed frame
                position[int'(m)*32 +: 32]         <= {pos_hi, pos_lo};
                velocity[int'(m)*WORD_W +: WORD_W] <= vel_s;
                displacement[int'(m)*WORD_W +: WORD_W] <= do_i;
                err_timeout[m] <= 1'b0;
              end
              default: ;
            endcase
          end
          if (state_nx == GAP) begin
            frame_done  <= 1'b1;
            frame_motor <= m;
            gap_cnt     <= '0;
            if (timed_out) err_timeout[m] <= 1'b1;
          end
        end
        GAP: begin
          if (gap_end) begin
            if (next_found) begin
              m <= next_idx;
            end else begin
              scan_done <= 1'b1;
              if (state_nx == SELECT) begin
                m      <= first_idx;
                en_q   <= motor_en;
                cont_q <= continuous;
              end else begin
                busy <= 1'b0;
              end
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myo_spi_scanner.sv
// tb/tb_myo_spi_scanner.sv - self-checking bench for myo_spi_scanner with a model SPI slave
module tb_myo_spi_scanner;

  localparam int NM = 10;
  localparam int WW = 16;
  localparam int TO = 64;
  localparam int GC = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [NM-1:0]     motor_en = '0;
  logic [NM*WW-1:0]  pwm_ref;
  logic              di_req = 1'b0;
  logic              wr_ack = 1'b0;
  logic              do_valid = 1'b0;
  logic [WW-1:0]     do_i = '0;
  logic [WW-1:0]     di_o;
  logic              wren;
  logic [NM-1:0]     ss_n_o;
  logic [NM*32-1:0]  position;
  logic [NM*WW-1:0]  velocity, displacement;
  logic [NM-1:0]     err_timeout;
  logic              frame_done;
  logic [3:0]        frame_motor;
  logic              scan_done, busy;

  myo_spi_scanner #(.NUM_MOTORS(NM), .WORD_W(WW), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .continuous(continuous),
    .motor_en(motor_en), .pwm_ref(pwm_ref), .di_req(di_req), .wr_ack(wr_ack),
    .do_valid(do_valid), .do_i(do_i), .di_o(di_o), .wren(wren), .ss_n_o(ss_n_o),
    .position(position), .velocity(velocity), .displacement(displacement),
    .err_timeout(err_timeout), .frame_done(frame_done), .frame_motor(frame_motor),
    .scan_done(scan_done), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [WW-1:0] pwm_m [NM];
  logic [WW-1:0] reply [NM][5];
  logic [NM-1:0] silent = '0;
  logic          slave_on = 1'b1;

  always_comb begin
    pwm_ref = '0;
    for (int i = 0; i < NM; i++) pwm_ref[i*WW +: WW] = pwm_m[i];
  end

  // Reference state: what each motor's registers must hold after the scans so far
  logic [31:0]   exp_pos  [NM];
  logic [WW-1:0] exp_vel  [NM];
  logic [WW-1:0] exp_disp [NM];
  logic [NM-1:0] exp_err;

  int tests = 0;
  int fails = 0;

  // Monitor logs (monotonic counters, only written here)
  int fd_n = 0, scan_n = 0, scan_busy_n = 0, busy_n = 0, ss_low_n = 0, ss1_low_n = 0, ss_bad = 0;
  int fd_log [256];

  always @(negedge clock) begin
    if (reset_n) begin
      if (frame_done && fd_n < 256) begin fd_log[fd_n] = int'(frame_motor); fd_n++; end
      if (scan_done) begin scan_n++; if (busy) scan_busy_n++; end
      if (busy) busy_n++;
      if (ss_n_o != '1) ss_low_n++;
      if (!ss_n_o[1]) ss1_low_n++;
      if (!(ss_n_o == '1 || $onehot(~ss_n_o))) ss_bad++;
    end
  end

  // SPI master + slave board model: five words per selected frame, RX returned with each ack
  int sel_n = 0, tx_n = 0, slave_err = 0;
  int sel_log [256];
  logic [WW-1:0] tx_log [256];

  initial begin : slave
    forever begin
      @(negedge clock);
      if (slave_on && reset_n && ss_n_o != '1) begin : frame
        int mi;
        int n;
        mi = 0;
        for (int i = NM - 1; i >= 0; i--) if (!ss_n_o[i]) mi = i;
        if (sel_n < 256) begin sel_log[sel_n] = mi; sel_n++; end
        for (int w = 0; w < 5; w++) begin
          di_req = 1'b1;
          n = 0;
          do begin @(negedge clock); n++; end while (!wren && n < 50);
          if (!wren) begin slave_err++; break; end
          if (w == 0 && tx_n < 256) begin tx_log[tx_n] = di_o; tx_n++; end
          wr_ack = 1'b1;
          if (!silent[mi]) begin do_valid = 1'b1; do_i = reply[mi][w]; end
          @(negedge clock);
          wr_ack = 1'b0;
          do_valid = 1'b0;
        end
        di_req = 1'b0;
        n = 0;
        while (ss_n_o != '1 && n < 300) begin @(negedge clock); n++; end
        if (ss_n_o != '1) slave_err++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs();
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("pos[%0d]", m),  position[m*32 +: 32],     exp_pos[m]);
      chk($sformatf("vel[%0d]", m),  velocity[m*WW +: WW],     exp_vel[m]);
      chk($sformatf("disp[%0d]", m), displacement[m*WW +: WW], exp_disp[m]);
    end
    chk("err_timeout", err_timeout, exp_err);
  endtask

  task automatic model_reset();
    for (int m = 0; m < NM; m++) begin exp_pos[m] = '0; exp_vel[m] = '0; exp_disp[m] = '0; end
    exp_err = '0;
  endtask

  // One single-shot scan: drives start, waits, then checks order, TX words and registers
  task automatic run_scan(input logic [NM-1:0] mask, input logic [NM-1:0] sil);
    int f0, s0, t0, p0, b0, l0, n;
    int order [$];
    f0 = fd_n; s0 = scan_n; t0 = tx_n; p0 = sel_n; b0 = busy_n; l0 = ss_low_n;
    silent = sil;
    @(negedge clock); motor_en = mask; start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    if (mask != '0) begin
      while (scan_n == s0 && n < 4000) begin @(negedge clock); n++; end
      chk("scan_done_count", scan_n - s0, 1);
    end else begin
      repeat (30) @(negedge clock);
      chk("mask0_busy_cycles", busy_n - b0, 0);
      chk("mask0_ss_low_cycles", ss_low_n - l0, 0);
      chk("mask0_scan_done", scan_n - s0, 0);
    end
    repeat (3) @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_ss", ss_n_o, {NM{1'b1}});
    for (int m = 0; m < NM; m++) begin
      if (mask[m]) begin
        order.push_back(m);
        if (sil[m]) exp_err[m] = 1'b1;
        else begin
          exp_pos[m]  = {reply[m][1], reply[m][2]};
          exp_vel[m]  = reply[m][3];
          exp_disp[m] = reply[m][4];
          exp_err[m]  = 1'b0;
        end
      end
    end
    chk("frame_count", fd_n - f0, order.size());
    chk("select_count", sel_n - p0, order.size());
    for (int i = 0; i < order.size() && f0 + i < fd_n && p0 + i < sel_n && t0 + i < tx_n; i++) begin
      chk($sformatf("frame_motor[%0d]", i), fd_log[f0 + i], order[i]);
      chk($sformatf("select[%0d]", i), sel_log[p0 + i], order[i]);
      chk($sformatf("tx0[%0d]", i), tx_log[t0 + i], pwm_m[order[i]]);
    end
    check_regs();
  endtask

  typedef struct {
    logic [NM-1:0] mask;
    logic [NM-1:0] sil;
    int            exp_frames;
    logic [NM-1:0] exp_err;
  } vec_t;

  initial begin : main
    vec_t vt [5];
    int f0, s0, b0, l1, n, d;

    vt[0] = '{10'b0000000101, 10'b0000000000, 2, 10'b0000000000};
    vt[1] = '{10'b0000000000, 10'b0000000000, 0, 10'b0000000000};
    vt[2] = '{10'b0000001010, 10'b0000000010, 2, 10'b0000000010};
    vt[3] = '{10'b0000001000, 10'b0000001000, 1, 10'b0000001010};
    vt[4] = '{10'b0000001000, 10'b0000000000, 1, 10'b0000000010};

    for (int i = 0; i < NM; i++) begin
      pwm_m[i] = 16'h0100 + WW'(i);
      if (i == 0 || i == 2) begin
        reply[i][0] = 16'h0000; reply[i][1] = 16'h0001; reply[i][2] = 16'h8000;
        reply[i][3] = 16'hFFF0; reply[i][4] = 16'h0042;
      end else begin
        reply[i][0] = 16'h0000;       reply[i][1] = 16'h0100 + WW'(i); reply[i][2] = 16'h2000 + WW'(i);
        reply[i][3] = 16'h0010 + WW'(i); reply[i][4] = 16'h0300 + WW'(i);
      end
    end
    pwm_m[0] = 16'h1234;
    pwm_m[2] = 16'hABCD;
    model_reset();

    repeat (3) @(negedge clock);
    chk("rst_ss", ss_n_o, {NM{1'b1}});
    chk("rst_wren", wren, 0);
    chk("rst_di_o", di_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_position", position[63:0], 0);
    chk("rst_err", err_timeout, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) begin
      f0 = fd_n; l1 = ss1_low_n;
      run_scan(vt[i].mask, vt[i].sil);
      chk($sformatf("vec%0d_frames", i), fd_n - f0, vt[i].exp_frames);
      chk($sformatf("vec%0d_err", i), err_timeout, vt[i].exp_err);
      if (i == 2) begin
        d = ss1_low_n - l1;
        tests++;
        if (d < TO || d > TO + 2) begin
          fails++;
          $display("FAIL timeout_select_len: got %0d cycles, expected %0d..%0d", d, TO, TO + 2);
        end
      end
    end
    chk("plan_tx0", tx_log[0], 16'h1234);
    chk("plan_tx1", tx_log[1], 16'hABCD);
    chk("plan_pos0", position[31:0], 32'h00018000);
    chk("plan_vel0", velocity[15:0], 16'hFFF0);
    chk("plan_disp0", displacement[15:0], 16'h0042);
    chk("plan_pos2", position[95:64], 32'h00018000);
    chk("plan_vel2_neg16", 64'(int'($signed(velocity[47:32]))), 64'(-16));

    // Continuous scanning over all motors, dropped during the third scan
    silent = '0;
    f0 = fd_n; s0 = scan_n; b0 = scan_busy_n;
    @(negedge clock); motor_en = '1; continuous = 1'b1;
    n = 0;
    while (scan_n - s0 < 2 && n < 6000) begin @(negedge clock); n++; end
    continuous = 1'b0;
    n = 0;
    while ((busy || scan_n - s0 < 3) && n < 3000) begin @(negedge clock); n++; end
    repeat (5) @(negedge clock);
    chk("cont_scans", scan_n - s0, 3);
    chk("cont_frames", fd_n - f0, 3 * NM);
    chk("cont_busy_between_scans", scan_busy_n - b0, 2);
    chk("cont_busy_end", busy, 0);
    d = 0;
    for (int i = 0; i < 3 * NM && f0 + i < fd_n; i++) if (fd_log[f0 + i] != i % NM) d++;
    chk("cont_order_errors", d, 0);
    for (int m = 0; m < NM; m++) begin
      exp_pos[m] = {reply[m][1], reply[m][2]}; exp_vel[m] = reply[m][3]; exp_disp[m] = reply[m][4];
    end
    exp_err = '0;
    check_regs();

    // Randomised single-shot scans against the model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NM; i++) begin
        pwm_m[i] = WW'($urandom);
        for (int w = 0; w < 5; w++) reply[i][w] = WW'($urandom);
      end
      run_scan(NM'($urandom), NM'($urandom & $urandom & $urandom));
    end

    // Reset in the middle of a frame
    slave_on = 1'b0;
    @(negedge clock); motor_en = 10'b0000010000; start = 1'b1;
    @(negedge clock); start = 1'b0;
    n = 0;
    while (ss_n_o[4] && n < 20) begin @(negedge clock); n++; end
    chk("mid_sel", ss_n_o[4], 0);
    for (int w = 0; w < 2; w++) begin
      di_req = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!wren && n < 20);
      wr_ack = 1'b1; do_valid = 1'b1; do_i = 16'h1111 * WW'(w + 1);
      @(negedge clock);
      wr_ack = 1'b0; do_valid = 1'b0;
    end
    @(negedge clock);
    chk("mid_wren_before_reset", wren, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ss", ss_n_o, {NM{1'b1}});
    chk("mid_rst_wren", wren, 0);
    chk("mid_rst_busy", busy, 0);
    model_reset();
    check_regs();
    di_req = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    slave_on = 1'b1;
    repeat (2) @(negedge clock);
    run_scan(10'b0000010000, 10'b0000000000);

    chk("slave_protocol_errors", slave_err, 0);
    chk("ss_not_onehot_cycles", ss_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
